// File: rtl/crypt_pkg.sv
// crypt_pkg: shared state encoding and default sizes for the stream cipher blocks
package crypt_pkg;
    localparam int N_DEF = 7;
    localparam int KS_TIMEOUT_DEF = 1023;
    typedef enum logic [1:0] {IDLE, LOAD, WAIT_INIT, STREAM} state_e;
endpackage

// File: rtl/enc_out_fifo.sv
// enc_out_fifo: 2-entry in-order ciphertext buffer; push while full is only legal alongside a pop
module enc_out_fifo #(
    parameter int N = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [N-1:0] data_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [N-1:0] data_o
);
    logic [N-1:0] mem_q [2];
    logic         wr_q, rd_q;
    logic [1:0]   cnt_q, cnt_d;
    always_comb cnt_d = cnt_q + 2'(push_i) - 2'(pop_i);
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            if (push_i) mem_q[wr_q] <= data_i;
            wr_q  <= wr_q ^ push_i;
            rd_q  <= rd_q ^ pop_i;
            cnt_q <= cnt_d;
        end
    end
    assign full_o  = cnt_q == 2'd2;
    assign empty_o = cnt_q == 2'd0;
    assign data_o  = mem_q[rd_q];
endmodule

// File: rtl/encrypt_stream.sv
// encrypt_stream: XORs plaintext with rc4 keystream and owns generator start-up.
// Optional ENCRYPT_STREAM_CNT_EN adds a 16-bit accepted-character counter.
module encrypt_stream
    import crypt_pkg::*;
#(
    parameter int N          = N_DEF,
    parameter int KS_TIMEOUT = KS_TIMEOUT_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] password,
    output logic         ks_load,
    output logic [N-1:0] ks_password,
    input  logic         ks_init_done,
    input  logic         ks_valid,
    input  logic [N-1:0] ks_data,
    output logic         ks_pop,
    input  logic         in_valid,
    input  logic [N-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [N-1:0] out_data,
    input  logic         out_ready,
    output logic         busy,
    output logic         error
`ifdef ENCRYPT_STREAM_CNT_EN
    ,
    output logic [15:0]  char_count
`endif
);
    localparam int CW = $clog2(KS_TIMEOUT + 1);
    state_e        state_q;
    logic [CW-1:0] tmo_q;
    logic          ks_load_q, error_q;
    logic [N-1:0]  pwd_q;
    logic          full, empty, pop, accept, rekey;
    assign pop      = out_valid & out_ready;
    assign in_ready = (state_q == STREAM) & ks_valid & (~full | pop);
    assign accept   = in_valid & in_ready;
    assign rekey    = start & (state_q != LOAD);
    assign ks_pop   = accept;
    assign out_valid = ~empty;
    assign ks_load  = ks_load_q;
    assign ks_password = pwd_q;
    assign error    = error_q;
    assign busy     = state_q != IDLE;
    enc_out_fifo #(.N(N)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (accept),
        .pop_i   (pop),
        .data_i  (in_data ^ ks_data),
        .full_o  (full),
        .empty_o (empty),
        .data_o  (out_data)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tmo_q     <= '0;
            ks_load_q <= 1'b0;
            error_q   <= 1'b0;
            pwd_q     <= '0;
        end else begin
            ks_load_q <= 1'b0;
            if (rekey) begin
                pwd_q     <= password;
                error_q   <= 1'b0;
                ks_load_q <= 1'b1;
                state_q   <= LOAD;
            end else begin
                case (state_q)
                    LOAD: begin
                        tmo_q   <= '0;
                        state_q <= WAIT_INIT;
                    end
                    // init_done outranks a timeout landing on the same cycle
                    WAIT_INIT: begin
                        if (ks_init_done) state_q <= STREAM;
                        else if (tmo_q == CW'(KS_TIMEOUT - 1)) begin
                            error_q <= 1'b1;
                            state_q <= IDLE;
                        end else tmo_q <= tmo_q + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
`ifdef ENCRYPT_STREAM_CNT_EN
    logic [15:0] cnt_q;
    always_ff @(posedge clk) begin
        if (rst || rekey) cnt_q <= '0;
        else if (accept) cnt_q <= cnt_q + 16'd1;
    end
    assign char_count = cnt_q;
`endif
endmodule
